// File: rtl/register_bank_pkg.sv
// Shared types and sizing helpers for the register_bank register file.
package register_bank_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_REGBITS = 4;
    localparam int DEF_NREAD   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    function automatic int last_addr(input int regbits);
        return (1 << regbits) - 1;
    endfunction

endpackage

// File: rtl/register_bank_clear_fsm.sv
// Sequential clear engine: walks addresses 1..2**REGBITS-1 writing zero,
// holding busy high for the whole sequence.
module register_bank_clear_fsm
    import register_bank_pkg::*;
#(
    parameter int REGBITS = DEF_REGBITS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    output logic               busy,
    output logic               clr_we,
    output logic [REGBITS-1:0] clr_addr,
    output logic               clear_acc
);

    localparam logic [REGBITS-1:0] ONE  = REGBITS'(1);
    localparam logic [REGBITS-1:0] LAST = REGBITS'(last_addr(REGBITS));

    state_t             state, state_nxt;
    logic [REGBITS-1:0] ptr, ptr_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CLEAR;
            ptr   <= ONE;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // ptr wraps to zero on the exit edge; address 0 is never visited.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        clear_acc = 1'b0;
        case (state)
            IDLE: begin
                if (clear) begin
                    state_nxt = CLEAR;
                    ptr_nxt   = ONE;
                    clear_acc = 1'b1;
                end
            end
            CLEAR: begin
                ptr_nxt = ptr + ONE;
                if (ptr == LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = CLEAR;
                ptr_nxt   = ONE;
            end
        endcase
    end

    assign busy     = (state == CLEAR);
    assign clr_we   = (state == CLEAR);
    assign clr_addr = ptr;

endmodule

// File: rtl/register_bank.sv
// Multi-port register file with hardwired-zero register 0 and hardware clear.
// Optional same-cycle write-to-read bypass: define REGISTER_BANK_BYPASS_EN.
module register_bank
    import register_bank_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int REGBITS = DEF_REGBITS,
    parameter int NREAD   = DEF_NREAD
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     regwrite,
    input  logic [REGBITS-1:0]       wa,
    input  logic [WIDTH-1:0]         wd,
    input  logic                     clear,
    input  logic [NREAD*REGBITS-1:0] ra,
    output logic [NREAD*WIDTH-1:0]   rd,
    output logic                     busy,
    output logic                     wr_drop
);

    localparam int DEPTH = 1 << REGBITS;

    logic [WIDTH-1:0]   mem [DEPTH];
    logic               clr_we;
    logic [REGBITS-1:0] clr_addr;
    logic               clear_acc;
    logic               ext_we;
    logic               drop;
    logic               mem_we;
    logic [REGBITS-1:0] mem_addr;
    logic [WIDTH-1:0]   mem_wd;

    register_bank_clear_fsm #(
        .REGBITS(REGBITS)
    ) u_clear_fsm (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .clear_acc(clear_acc)
    );

    // External writes lose to the clear engine, including on the accepting edge.
    assign ext_we   = regwrite && !busy && !clear_acc && (wa != '0);
    assign drop     = regwrite && (busy || clear_acc);
    assign mem_we   = !reset && (clr_we || ext_we);
    assign mem_addr = clr_we ? clr_addr : wa;
    assign mem_wd   = clr_we ? '0 : wd;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_drop <= 1'b0;
        end else begin
            wr_drop <= drop;
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [REGBITS-1:0] ra_i;
        logic [WIDTH-1:0]   rd_i;

        assign ra_i = ra[i*REGBITS +: REGBITS];

        always_comb begin
            rd_i = mem[ra_i];
`ifdef REGISTER_BANK_BYPASS_EN
            if (regwrite && (wa == ra_i)) begin
                rd_i = wd;
            end
`endif
            if (busy || (ra_i == '0)) begin
                rd_i = '0;
            end
        end

        assign rd[i*WIDTH +: WIDTH] = rd_i;
    end

endmodule
